// File: rtl/multi_mode_buffer_seq.sv
// -----------------------------------------------------------------------------
// multi_mode_buffer_seq
//
// Sequencer for the multi-mode input buffer in front of the systolic array.
// A LOAD command fills the buffer with BUFFER_DEPTH beats in load mode. A
// STREAM command pushes cmd_len beats through in stream mode, then drains
// the diagonal skew so that every lane sees its full window.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (accepted only while idle)
//   cmd_op              0 = LOAD, 1 = STREAM
//   cmd_len             STREAM beat count (ignored for LOAD)
//   in_valid/ready      upstream data beat handshake
//   buf_mode            buffer mode: 0 = load, 1 = stream (holds while idle)
//   buf_shift_en        advance the buffer this cycle
//   lane_en             skewed per-lane data-valid mask
//   out_valid           result beat at the array edge (lane_en[N-1])
//   busy                a command is in progress
//   done                one-cycle completion pulse, first idle cycle
//   perf_stall_cycles   saturating count of upstream stall cycles
//                       (only when MULTI_MODE_BUFFER_SEQ_PERF_EN is defined)
// -----------------------------------------------------------------------------
module multi_mode_buffer_seq #(
  parameter int NUMBER_OF_BUFFERS = 4,
  parameter int BUFFER_DEPTH      = NUMBER_OF_BUFFERS,
  parameter int LEN_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         buf_mode,
  output logic                         buf_shift_en,
  output logic [NUMBER_OF_BUFFERS-1:0] lane_en,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done
`ifdef MULTI_MODE_BUFFER_SEQ_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cycles
`endif
);

  localparam int N        = NUMBER_OF_BUFFERS;
  localparam int LOAD_CW  = $clog2(BUFFER_DEPTH + 1);
  localparam int DRAIN_CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [LOAD_CW-1:0]   load_cnt;
  logic [LEN_WIDTH-1:0] stream_cnt;
  logic [DRAIN_CW-1:0]  drain_cnt;
  logic                 done_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    state_d      = state_q;
    cmd_ready    = 1'b0;
    in_ready     = 1'b0;
    buf_shift_en = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!cmd_op) begin
            state_d = S_LOAD;
          end else if (cmd_len != '0) begin
            state_d = S_STREAM;
          end else begin
            // Zero-length stream: nothing to move, just acknowledge.
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        in_ready     = 1'b1;
        buf_shift_en = in_valid;
        if (in_valid && load_cnt == LOAD_CW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_STREAM: begin
        in_ready     = 1'b1;
        buf_shift_en = in_valid;
        if (in_valid && stream_cnt == LEN_WIDTH'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        buf_shift_en = 1'b1;
        if (drain_cnt == DRAIN_CW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, skew mask, mode and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt   <= '0;
      stream_cnt <= '0;
      drain_cnt  <= '0;
      lane_en    <= '0;
      buf_mode   <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      done <= done_d;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (!cmd_op) begin
              load_cnt <= LOAD_CW'(BUFFER_DEPTH);
              buf_mode <= 1'b0;
            end else if (cmd_len != '0) begin
              stream_cnt <= cmd_len;
              buf_mode   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            load_cnt <= load_cnt - LOAD_CW'(1);
          end
        end
        S_STREAM: begin
          if (in_valid) begin
            stream_cnt <= stream_cnt - LEN_WIDTH'(1);
            // Shift a one in at lane 0; the shift form also covers N == 1.
            lane_en    <= (lane_en << 1) | N'(1);
            if (stream_cnt == LEN_WIDTH'(1)) begin
              drain_cnt <= DRAIN_CW'(N);
            end
          end
        end
        S_DRAIN: begin
          lane_en   <= lane_en << 1;
          drain_cnt <= drain_cnt - DRAIN_CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_valid = lane_en[N-1];
  assign busy      = (state_q != S_IDLE);

`ifdef MULTI_MODE_BUFFER_SEQ_PERF_EN
  // Upstream stall cycles while the buffer is waiting on data; saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
    end else if ((state_q == S_LOAD || state_q == S_STREAM) && !in_valid &&
                 perf_stall_cycles != '1) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_mode_buffer_seq.sv
// -----------------------------------------------------------------------------
// tb_multi_mode_buffer_seq
//
// Self-checking bench for multi_mode_buffer_seq (N = 4, BUFFER_DEPTH = 4).
// The reference model tracks the command in progress as a phase, a remaining
// beat/drain count and a total shift count. The expected skew mask is derived
// arithmetically: a STREAM of length L shifts in L ones followed by zeros, so
// after s shifts lane i is set exactly when 1 <= s - i <= L.
// -----------------------------------------------------------------------------
module tb_multi_mode_buffer_seq;

  localparam int N  = 4;
  localparam int BD = 4;
  localparam int LW = 16;
  localparam int VW = N + 7;
  localparam logic [VW-1:0] RST_VEC = {1'b1, {(VW-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          buf_mode;
  logic          buf_shift_en;
  logic [N-1:0]  lane_en;
  logic          out_valid;
  logic          busy;
  logic          done;
`ifdef MULTI_MODE_BUFFER_SEQ_PERF_EN
  logic [31:0]   perf_stall_cycles;
`endif

  multi_mode_buffer_seq #(
    .NUMBER_OF_BUFFERS(N),
    .BUFFER_DEPTH     (BD),
    .LEN_WIDTH        (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_len          (cmd_len),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .buf_mode         (buf_mode),
    .buf_shift_en     (buf_shift_en),
    .lane_en          (lane_en),
    .out_valid        (out_valid),
    .busy             (busy),
    .done             (done)
`ifdef MULTI_MODE_BUFFER_SEQ_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: 0 idle, 1 load, 2 stream, 3 drain.
  int     m_phase, m_rem, m_len, m_shifts;
  logic   m_done, m_mode;
  longint m_stalls;

  // Snapshots taken at the sampling point of the latest cycle.
  logic [N-1:0] s_lane;
  logic         s_done, s_busy, s_cmd_ready;

  function automatic logic [N-1:0] exp_lane();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (m_shifts - i >= 1 && m_shifts - i <= m_len) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] l;
    logic         sh;
    l  = exp_lane();
    sh = ((m_phase == 1 || m_phase == 2) && in_valid) || (m_phase == 3);
    return {(m_phase == 0), (m_phase == 1 || m_phase == 2), m_mode, sh, l,
            l[N-1], (m_phase != 0), m_done};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {cmd_ready, in_ready, buf_mode, buf_shift_en, lane_en, out_valid,
            busy, done};
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_rem    = 0;
    m_len    = 0;
    m_shifts = 0;
    m_done   = 1'b0;
    m_mode   = 1'b0;
    m_stalls = 0;
  endtask

  // Advance the model across one active edge using the current inputs.
  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    case (m_phase)
      0: if (cmd_valid) begin
        if (!cmd_op) begin
          m_phase = 1; m_rem = BD; m_mode = 1'b0;
        end else if (cmd_len == 0) begin
          nd = 1'b1;
        end else begin
          m_phase = 2; m_rem = int'(cmd_len); m_len = int'(cmd_len);
          m_shifts = 0; m_mode = 1'b1;
        end
      end
      1: if (in_valid) begin
        m_rem--;
        if (m_rem == 0) begin m_phase = 0; nd = 1'b1; end
      end else m_stalls++;
      2: if (in_valid) begin
        m_rem--; m_shifts++;
        if (m_rem == 0) begin m_phase = 3; m_rem = N; end
      end else m_stalls++;
      default: begin
        m_shifts++; m_rem--;
        if (m_rem == 0) begin m_phase = 0; nd = 1'b1; end
      end
    endcase
    m_done = nd;
  endtask

  // One clock cycle: sample at the falling edge, then step past the rising
  // edge. Entered and left 1 time unit after a rising edge.
  task automatic run_cycle(output logic [VW-1:0] obs, output logic [VW-1:0] exp,
                           output logic acc);
    @(negedge clk);
    obs         = obs_vec();
    exp         = exp_vec();
    s_lane      = lane_en;
    s_done      = done;
    s_busy      = busy;
    s_cmd_ready = cmd_ready;
    acc         = (m_phase == 0) && cmd_valid;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = '0; in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] o;
    cmd_valid = 1'b0; in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    o = obs_vec();
    if (o !== RST_VEC) begin
      mismatched++; $display("FAIL reset_values: got %b want %b", o, RST_VEC);
    end
    compared++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    logic [VW-1:0] o, e; logic a;
    cmd_valid = 1'b1; cmd_op = 1'b0; in_valid = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      run_cycle(o, e, a);
      if (o !== e) begin mismatched++; $display("FAIL load c%0d: got %b want %b", c, o, e); end
      compared++;
      if (s_done !== (c == 5) || s_busy !== (c >= 1 && c <= 4)) begin
        mismatched++;
        $display("FAIL load_timing c%0d: done %b busy %b", c, s_done, s_busy);
      end
      compared++;
      if (c == 0) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_stream_l3();
    logic [VW-1:0] o, e; logic a;
    logic [N-1:0] tab [7];
    tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = LW'(3); in_valid = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      run_cycle(o, e, a);
      if (o !== e) begin mismatched++; $display("FAIL stream3 c%0d: got %b want %b", c, o, e); end
      compared++;
      if (c >= 2 && c <= 8) begin
        if (s_lane !== tab[c-2]) begin
          mismatched++; $display("FAIL stream3_lane c%0d: got %b want %b", c, s_lane, tab[c-2]);
        end
        compared++;
      end
      if (s_done !== (c == 8)) begin
        mismatched++; $display("FAIL stream3_done c%0d: got %b want %b", c, s_done, (c == 8));
      end
      compared++;
      if (c == 0) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_stream_stall();
    logic [VW-1:0] o, e; logic a;
`ifdef MULTI_MODE_BUFFER_SEQ_PERF_EN
    logic [31:0] p0;
    p0 = perf_stall_cycles;
`endif
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = LW'(2);
    for (int c = 0; c <= 10; c++) begin
      in_valid = !(c == 2 || c == 3);
      run_cycle(o, e, a);
      if (o !== e) begin mismatched++; $display("FAIL stall c%0d: got %b want %b", c, o, e); end
      compared++;
      if (s_done !== (c == 9)) begin
        mismatched++; $display("FAIL stall_done c%0d: got %b want %b", c, s_done, (c == 9));
      end
      compared++;
      if (c == 0) cmd_valid = 1'b0;
    end
    in_valid = 1'b1;
`ifdef MULTI_MODE_BUFFER_SEQ_PERF_EN
    if (perf_stall_cycles - p0 !== 32'd2) begin
      mismatched++; $display("FAIL stall_perf: got %0d want 2", perf_stall_cycles - p0);
    end
    compared++;
`endif
  endtask

  task automatic test_zero_len();
    logic [VW-1:0] o, e; logic a;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = '0; in_valid = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      run_cycle(o, e, a);
      if (o !== e) begin mismatched++; $display("FAIL zero_len c%0d: got %b want %b", c, o, e); end
      compared++;
      if (s_done !== (c == 1) || s_busy !== 1'b0) begin
        mismatched++; $display("FAIL zero_len_timing c%0d: done %b busy %b", c, s_done, s_busy);
      end
      compared++;
      if (c == 0) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    logic [VW-1:0] o, e; logic a;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = LW'(5); in_valid = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      run_cycle(o, e, a);
      if (o !== e) begin mismatched++; $display("FAIL abort c%0d: got %b want %b", c, o, e); end
      compared++;
      if (c == 0) cmd_valid = 1'b0;
    end
    // Mid cycle 3: pull reset between edges.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    o = obs_vec();
    if (o !== RST_VEC) begin mismatched++; $display("FAIL abort_async: got %b want %b", o, RST_VEC); end
    compared++;
    @(posedge clk);
    @(negedge clk);
    o = obs_vec();
    if (o !== RST_VEC) begin mismatched++; $display("FAIL abort_hold: got %b want %b", o, RST_VEC); end
    compared++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_load();
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] o, e; logic a;
    cmd_valid = 1'b1; cmd_op = 1'b0; in_valid = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      if (c == 5) begin cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = LW'(2); end
      run_cycle(o, e, a);
      if (o !== e) begin mismatched++; $display("FAIL b2b c%0d: got %b want %b", c, o, e); end
      compared++;
      if (c == 5 && !(s_done === 1'b1 && s_cmd_ready === 1'b1 && a)) begin
        mismatched++; $display("FAIL b2b_accept: done %b cmd_ready %b", s_done, s_cmd_ready);
      end
      if (c == 6 && s_busy !== 1'b1) begin
        mismatched++; $display("FAIL b2b_busy: got %b want 1", s_busy);
      end
      if (c == 12 && s_done !== 1'b1) begin
        mismatched++; $display("FAIL b2b_done: got %b want 1", s_done);
      end
      if (c == 5 || c == 6 || c == 12) compared++;
      if (c == 0 || c == 5) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] o, e; logic a;
    cmd_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!cmd_valid && $urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b1;
        cmd_op    = 1'($urandom_range(0, 1));
        cmd_len   = LW'($urandom_range(0, 9));
      end
      in_valid = ($urandom_range(0, 3) != 0);
      run_cycle(o, e, a);
      if (o !== e) begin mismatched++; $display("FAIL random c%0d: got %b want %b", c, o, e); end
      compared++;
      if (a) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
`ifdef MULTI_MODE_BUFFER_SEQ_PERF_EN
    if (perf_stall_cycles !== m_stalls[31:0]) begin
      mismatched++;
      $display("FAIL random_perf: got %0d want %0d", perf_stall_cycles, m_stalls[31:0]);
    end
    compared++;
`endif
  endtask

  initial begin
    model_reset();
    do_reset();
    test_reset();
    test_load();
    test_stream_l3();
    test_stream_stall();
    test_zero_len();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
